fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID buffer.
- Owns the word-addressed PC and drives a req/ack instruction-memory interface.
- Holds one fetched instruction in an output slot with a valid/ready handshake toward decode.
- Accepts a redirect (taken branch/jump target) from write-back and squashes wrong-path fetches, including a memory request still outstanding.

Parameters:
- RESET_PC, 32'd0: PC value loaded on reset.
- ADDR_W, 32: PC / memory address width.
- INSTR_W, 32: instruction width.

Ports:
- clock  in  1  rising-edge clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  ADDR_W-bit addr phase valid (1 bit)  fetch request to instruction memory.
- imem_addr  out  ADDR_W  fetch address; stable while imem_req=1 and no ack has arrived.
- imem_ack  in  1  memory completion; imem_data is valid in the ack cycle; may arrive in the same cycle as req.
- imem_data  in  INSTR_W  fetched instruction.
- redirect  in  1  taken branch/jump from write-back.
- redirect_pc  in  ADDR_W  new PC, sampled when redirect=1.
- id_ready  in  1  decode can accept the output slot this cycle.
- if_valid  out  1  output slot holds a valid instruction.
- if_instr  out  INSTR_W  instruction in the output slot.
- if_pc  out  ADDR_W  PC of if_instr.
- if_pc_plus_1  out  ADDR_W  if_pc + 1, modulo 2^ADDR_W.

Behaviour:
- Reset: pc=RESET_PC, state=FETCH, if_valid=0, if_instr=0, if_pc=0, if_pc_plus_1=0.
  - imem_req is forced to 0 while reset=1.
  - Reset asserted mid-request abandons the request; a late ack after reset is ignored in FETCH only if imem_req=0.
- PC arithmetic: word addressing, next sequential PC = pc+1, wraps from all-ones to 0. imem_addr = pc in FETCH/WAIT; it holds the old pc in SQUASH.
- Transfer: occurs in any cycle where if_valid && id_ready. The slot is "free" when !if_valid || id_ready.
- States:
  - FETCH: imem_req = slot free.
    - req && ack: load the slot (if_valid=1, if_instr=imem_data, if_pc=pc), pc<=pc+1, stay in FETCH. This gives throughput of 1 per cycle with a zero-wait memory.
    - req && !ack: go to WAIT.
  - WAIT: imem_req=1 regardless of id_ready, and the address is held.
    - Ack: load the slot (it is guaranteed empty), pc<=pc+1, go to FETCH.
  - SQUASH: imem_req=1 and imem_addr = the old in-flight address.
    - Ack: discard the data, pc<=pending_pc, go to FETCH.
- Redirect has priority over every other event in the same cycle:
  - if_valid is cleared next cycle, even if id_ready=1. The transfer in the redirect cycle itself still counts.
  - In FETCH with req&&ack, or with no req: drop the data, pc<=redirect_pc, stay in FETCH.
  - In FETCH with req&&!ack, or in WAIT without ack: pending_pc<=redirect_pc, go to SQUASH.
  - In WAIT with ack: drop the data, pc<=redirect_pc, go to FETCH.
  - In SQUASH without ack: pending_pc<=redirect_pc (the latest redirect wins), stay in SQUASH.
  - In SQUASH with ack: pc<=redirect_pc, go to FETCH.
- Slot consumed with no new load: if_valid<=0; if_instr and if_pc keep their old values.
- Latency: the instruction appears on if_* in the cycle after its ack.

Optional Feature:
- Macro FETCH_SQUASH_COUNT_EN.
- Defined:
  - Adds output squash_count (16 bits, reset 0).
  - Increments by 1 for each fetched instruction discarded: a slot cleared by redirect while valid, data dropped in a redirect+ack cycle, or an ack consumed in SQUASH.
  - Saturates at 16'hFFFF.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Zero-wait memory (ack=req), id_ready=1, 4 cycles after reset -> imem_addr 0,1,2,3; if_pc 0,1,2 on consecutive cycles; if_valid=1 from cycle 2.
- Ack delayed 2 cycles, id_ready=1 -> imem_addr=5 held stable for 3 cycles; if_pc=5, if_pc_plus_1=6 one cycle after ack.
- id_ready=0 with a valid slot (if_pc=7) -> imem_req=0; slot holds 7 until id_ready=1; the next fetch is addr 8.
- Redirect to 0x40 while WAIT on addr 9, ack 2 cycles later -> the data for 9 never reaches if_valid; the next imem_addr is 0x40. With FETCH_SQUASH_COUNT_EN, squash_count=1.
- Redirect to 0x20 then 0x30 on two cycles in SQUASH -> after ack, fetch goes to 0x30; 0x20 is never requested.
- PC=32'hFFFFFFFF, zero-wait fetch -> if_pc_plus_1=0, next imem_addr=0; reset mid-WAIT -> pc=RESET_PC, if_valid=0 on the next cycle.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with req/ack imem port, one-entry output slot and redirect squashing
// Ports: clock/reset (sync, active-high); imem_req/imem_addr/imem_ack/imem_data to instruction memory;
//        redirect/redirect_pc from write-back; id_ready/if_valid/if_instr/if_pc/if_pc_plus_1 toward decode.
// Optional: define FETCH_SQUASH_COUNT_EN to add squash_count (saturating count of discarded fetches).
module fetch_stage #(
    parameter int ADDR_W = 32,
    parameter int INSTR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               id_ready,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_plus_1
`ifdef FETCH_SQUASH_COUNT_EN
    ,
    output logic [15:0]        squash_count
`endif
);
    typedef enum logic [1:0] {FETCH, WAIT, SQUASH} state_t;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pend_q, pend_d, ipc_q, ipc_d, ip1_q, ip1_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic valid_q, valid_d, take;
    // pc_q is untouched while a request is outstanding, so it doubles as the in-flight address in SQUASH
    assign imem_addr = pc_q;
    assign if_valid = valid_q;
    assign if_instr = instr_q;
    assign if_pc = ipc_q;
    assign if_pc_plus_1 = ip1_q;
    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        pend_d = pend_q;
        valid_d = valid_q && !id_ready;
        instr_d = instr_q;
        ipc_d = ipc_q;
        ip1_d = ip1_q;
        imem_req = !reset && (state_q != FETCH || !valid_q || id_ready);
        take = imem_req && imem_ack;
        if (redirect) begin
            valid_d = 1'b0;
            if (imem_req && !take) begin
                pend_d = redirect_pc;
                state_d = SQUASH;
            end else begin
                pc_d = redirect_pc;
                state_d = FETCH;
            end
        end else if (take) begin
            state_d = FETCH;
            if (state_q == SQUASH) begin
                pc_d = pend_q;
            end else begin
                valid_d = 1'b1;
                instr_d = imem_data;
                ipc_d = pc_q;
                ip1_d = pc_q + ADDR_W'(1);
                pc_d = ip1_d;
            end
        end else if (imem_req && state_q == FETCH) begin
            state_d = WAIT;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q <= RESET_PC;
            pend_q <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q <= '0;
            ip1_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            pend_q <= pend_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q <= ipc_d;
            ip1_q <= ip1_d;
        end
    end
`ifdef FETCH_SQUASH_COUNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic [1:0] inc;
    logic [17:0] sum;
    // a redirect can drop a held slot and an acked fetch in the same cycle
    always_comb begin
        inc = {1'b0, redirect && valid_q && !id_ready} + {1'b0, take && (redirect || state_q == SQUASH)};
        sum = 18'(cnt_q) + 18'(inc);
        cnt_d = sum > 18'hFFFF ? 16'hFFFF : sum[15:0];
    end
    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign squash_count = cnt_q;
`endif
endmodule
